// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter: packet-locked round-robin merge of per-port RX FIFO byte streams,
// with a stall watchdog that drops a grant whose source stops delivering mid-packet.
module rx_port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W = 2,
  parameter int TIMEOUT = 64,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_PORTS-1:0] in_valid,
  input  logic [8*NUM_PORTS-1:0] in_data,
  input  logic [NUM_PORTS-1:0] in_last,
  output logic [NUM_PORTS-1:0] in_ready,
  output logic out_valid,
  output logic [7:0] out_data,
  output logic out_last,
  output logic out_sop,
  output logic [PORT_W-1:0] out_port,
  input  logic out_ready,
  output logic abort,
  output logic busy
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_nx;
  logic [PORT_W-1:0] grant, last_grant, pick;
  logic [TO_W-1:0] stall_cnt;
  logic sop_pend, lock, g_valid, hs, done, expire, found;
  // search starts just above the previous winner so it ends up lowest priority
  always_comb begin
    pick = grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && in_valid[(int'(last_grant) + k) % NUM_PORTS]) begin
        pick = PORT_W'((int'(last_grant) + k) % NUM_PORTS);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    lock = state == LOCK;
    g_valid = in_valid[grant];
    out_valid = lock & g_valid;
    out_data = lock ? in_data[8*int'(grant) +: 8] : 8'h00;
    out_last = lock & in_last[grant];
    out_sop = lock & sop_pend & g_valid;
    out_port = grant;
    busy = lock;
    in_ready = lock && out_ready ? NUM_PORTS'(1) << grant : '0;
    hs = out_valid & out_ready;
    done = hs & out_last;
    expire = TIMEOUT > 0 && lock && !g_valid && stall_cnt == TO_W'(TIMEOUT - 1);
    state_nx = state == IDLE ? (|in_valid ? LOCK : IDLE) : (done || expire ? IDLE : LOCK);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      sop_pend <= 1'b0;
      stall_cnt <= '0;
      abort <= 1'b0;
    end else begin
      abort <= expire;
      if (!lock && |in_valid) begin
        grant <= pick;
        sop_pend <= 1'b1;
        stall_cnt <= '0;
      end
      if (lock) begin
        if (hs) sop_pend <= 1'b0;
        if (done || expire) last_grant <= grant;
        // backpressure with valid data is not starvation, so only a missing byte counts
        stall_cnt <= g_valid || TIMEOUT == 0 ? '0 : stall_cnt + TO_W'(1);
      end
    end
  end
endmodule

// File: doc/rx_port_arbiter.md
# rx_port_arbiter

Packet-granular round-robin arbiter that merges NUM_PORTS per-port MAC RX FIFO byte streams into the single byte stream consumed by the header buffer / parser. It sits between the per-port RX FIFOs and the header buffer. A grant is locked for a whole packet, so packets are never interleaved. A stall watchdog releases a grant held by a port that stops delivering bytes mid-packet.

## Interface
- NUM_PORTS, 4: number of RX FIFO inputs; must be 2..16.
- PORT_W, 2: width of the port index; must equal ceil(log2(NUM_PORTS)).
- TIMEOUT, 64: consecutive mid-packet starvation cycles before abort; 0 disables the watchdog.
- TO_W, 8: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_PORTS  per-port byte valid from the RX FIFOs.
- in_data  in  8*NUM_PORTS  flattened bytes; port p occupies bits [8p+7:8p].
- in_last  in  NUM_PORTS  per-port last-byte-of-packet flag.
- in_ready  out  NUM_PORTS  per-port ready back to the RX FIFOs.
- out_valid  out  1  merged byte valid to the header buffer.
- out_data  out  8  merged byte.
- out_last  out  1  last byte of the packet.
- out_sop  out  1  high on the first byte of each packet.
- out_port  out  PORT_W  index of the granted port.
- out_ready  in  1  header buffer ready.
- abort  out  1  one-cycle pulse when the watchdog releases a grant.
- busy  out  1  high while a grant is held (LOCK state).

## Operation
- Two states, IDLE and LOCK; registers are state, grant, last_grant, sop_pend and stall_cnt.
- IDLE:
  - If any in_valid bit is set, pick the first set bit searching upward (modulo NUM_PORTS) from last_grant+1.
  - Register the pick into grant, set sop_pend=1, clear stall_cnt and move to LOCK.
  - In IDLE every in_ready bit, out_valid, out_last and out_sop is 0, and out_data=0.
- LOCK, datapath is combinational from the granted port:
  - out_valid=in_valid[grant], out_data=in_data[grant], out_last=in_last[grant].
  - out_sop=sop_pend&in_valid[grant].
  - in_ready[grant]=out_ready; all other in_ready bits are 0.
  - out_port=grant.
- Byte handshake in LOCK is out_valid&out_ready:
  - Any handshake clears sop_pend.
  - A handshake with out_last=1 sets last_grant<=grant and moves to IDLE.
- Watchdog (TIMEOUT>0, LOCK only):
  - in_valid[grant]=0 increments stall_cnt; in_valid[grant]=1 clears it.
  - Cycles where out_ready=0 but in_valid[grant]=1 do not count, because downstream backpressure is not a source fault.
  - When stall_cnt reaches TIMEOUT-1 and in_valid[grant] is still 0: register abort=1 for the next cycle, set last_grant<=grant, go to IDLE.
  - No byte is emitted or synthesized on abort; the header buffer discards the partial packet when it sees abort.
- Fairness: after a packet or abort from port p, port p has the lowest priority at the next arbitration.
- Signal changes on non-granted ports are ignored during LOCK.
- out_port holds its last value in IDLE.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1 (port 0 wins first), sop_pend=0, stall_cnt=0.
  - abort=0, busy=0, out_port=0.
  - All in_ready bits, out_valid, out_last, out_sop and out_data are 0.
- Grant latency: a request seen in IDLE in cycle N gives LOCK in N+1; the first byte can transfer in N+1.
- Packet turnaround: one IDLE bubble cycle after each last byte, so a 1-byte packet costs 2 cycles minimum.
- Data path latency: zero cycles in LOCK, purely combinational; in_ready depends combinationally on out_ready.
- abort is registered: high exactly one cycle, coincident with the first IDLE cycle.
- Reset mid-packet returns to IDLE immediately with all outputs at their reset values; the partial packet is abandoned.
- A last handshake and watchdog expiry cannot coincide, because expiry requires in_valid[grant]=0.

## Test plan
- Reset, then a single 3-byte packet on port 2 → grant in cycle 1, out_port=2, out_sop only on byte 0, out_last on byte 2, IDLE one cycle, busy 1 for 3 cycles.
- All 4 ports hold 2-byte packets continuously → grant order 0,1,2,3,0; each packet takes 3 cycles; no interleaving.
- Port 1 is locked; out_ready is toggled low 10 cycles mid-packet with in_valid[1]=1 → bytes are held stable, no abort, all bytes delivered in order.
- TIMEOUT=8, port 3 sends 2 bytes then drops valid → abort pulses 1 cycle, 8 cycles after the last valid; next grant goes to port 0 if it is requesting.
- Port 0 is continuously requesting, port 1 requests once → port 1 is granted right after port 0's current packet, never starved.
- rst_n asserted while port 2 is mid-packet → busy=0 and in_ready=0 immediately; after release, port 0 has first priority.
